// File: rtl/regfile_status.sv
// regfile_status: 32 x 64-bit register file with two registered read ports,
// one write-back port with same-cycle write-through, and a 4-bit flag register.
// The top index is the hard-wired zero register.
module regfile_status #(
  parameter int DATA_WIDTH = 64,
  parameter int REG_COUNT  = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] SA,
  input  logic [ADDR_WIDTH-1:0] SB,
  input  logic [ADDR_WIDTH-1:0] DA,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic                  W,
  input  logic [3:0]            status_in,
  input  logic                  set_flags,
  output logic [DATA_WIDTH-1:0] A,
  output logic [DATA_WIDTH-1:0] B,
  output logic [3:0]            flags
);

  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_COUNT - 1);

  logic [DATA_WIDTH-1:0] r_regs [REG_COUNT];
  logic [DATA_WIDTH-1:0] r_a, r_b;
  logic [3:0]            r_flags;

  logic                  w_wr_en;
  logic [DATA_WIDTH-1:0] w_a_val, w_b_val;

  // Writes to the zero register are dropped so its storage stays 0.
  assign w_wr_en = W && (DA != ZERO_IDX);

  // Operand selection: zero register first, then write-through, then storage.
  always_comb begin
    w_a_val = r_regs[SA];
    w_b_val = r_regs[SB];
    if (W && (DA == SA)) w_a_val = D;
    if (W && (DA == SB)) w_b_val = D;
    if (SA == ZERO_IDX)  w_a_val = '0;
    if (SB == ZERO_IDX)  w_b_val = '0;
  end

  // Register storage; reset wins over any write in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[DA] <= D;
    end
  end

  // Registered operand ports, reloaded every non-reset edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_a <= '0;
      r_b <= '0;
    end else begin
      r_a <= w_a_val;
      r_b <= w_b_val;
    end
  end

  // Flag register captures ALU status only on flag-setting instructions.
  always_ff @(posedge clock) begin
    if (reset)          r_flags <= '0;
    else if (set_flags) r_flags <= status_in;
  end

  assign A     = r_a;
  assign B     = r_b;
  assign flags = r_flags;

endmodule

// File: tb/tb_regfile_status.sv
// tb_regfile_status: directed scenarios plus randomized traffic, checked
// against an array-based model of the register file and flag register.
module tb_regfile_status;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  SA, SB, DA;
  logic [63:0] D;
  logic        W;
  logic [3:0]  status_in;
  logic        set_flags;
  logic [63:0] A, B;
  logic [3:0]  flags;

  int total = 0;
  int bad   = 0;

  // model state
  logic [63:0] m_reg [32];
  logic [63:0] m_a, m_b;
  logic [3:0]  m_flags;

  regfile_status #(.DATA_WIDTH(64), .REG_COUNT(32), .ADDR_WIDTH(5)) dut (
    .clock(clock), .reset(reset), .SA(SA), .SB(SB), .DA(DA), .D(D), .W(W),
    .status_in(status_in), .set_flags(set_flags), .A(A), .B(B), .flags(flags)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // what a read of register x returns in the current cycle
  function automatic logic [63:0] mval(input logic [4:0] x);
    if (x == 5'd31) return 64'd0;
    if (W && DA == x) return D;
    return m_reg[x];
  endfunction

  // apply one cycle of inputs, advance model, sample outputs after the edge
  task automatic step(input logic rst, input logic w, input logic [4:0] da,
                      input logic [63:0] d, input logic [4:0] sa, input logic [4:0] sb,
                      input logic sf, input logic [3:0] st);
    reset = rst; W = w; DA = da; D = d; SA = sa; SB = sb;
    set_flags = sf; status_in = st;
    if (rst) begin
      foreach (m_reg[i]) m_reg[i] = 64'd0;
      m_a = 64'd0; m_b = 64'd0; m_flags = 4'd0;
    end else begin
      m_a = mval(sa);
      m_b = mval(sb);
      if (w && da != 5'd31) m_reg[da] = d;
      if (sf) m_flags = st;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".A"}, A, m_a);
    chk({tag, ".B"}, B, m_b);
    chk({tag, ".flags"}, {60'd0, flags}, {60'd0, m_flags});
  endtask

  initial begin
    logic [63:0] f;
    reset = 1'b0; W = 1'b0; DA = '0; D = '0; SA = '0; SB = '0;
    set_flags = 1'b0; status_in = '0;
    foreach (m_reg[i]) m_reg[i] = 64'd0;
    m_a = '0; m_b = '0; m_flags = '0;
    @(negedge clock);

    // reset clear
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst.A", A, 64'd0); chk("rst.B", B, 64'd0); chk("rst.flags", {60'd0, flags}, 64'd0);
    step(0, 1, 3, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1, 4'hF);
    step(1, 1, 3, 64'h1234, 0, 0, 1, 4'h7);   // write and flags lost in reset cycle
    step(0, 0, 0, 0, 3, 31, 0, 0);
    chk("rstclr.A", A, 64'd0); chk("rstclr.B", B, 64'd0);
    chk("rstclr.flags", {60'd0, flags}, 64'd0);

    // write/read, ALU AND-style result 2&5=0
    step(0, 1, 2, 64'd2, 0, 0, 0, 0);
    step(0, 1, 5, 64'd5, 0, 0, 0, 0);
    step(0, 0, 0, 0, 2, 5, 0, 0);
    chk("wr.A", A, 64'd2); chk("wr.B", B, 64'd5);
    f = m_a & m_b;
    chk("wr.F", f, 64'd0);

    // zero register
    step(0, 1, 31, 64'h8000_0000_0000_0000, 31, 31, 0, 0);
    chk("zero.bypass", A, 64'd0);
    step(0, 0, 0, 0, 31, 31, 0, 0);
    chk("zero.A", A, 64'd0);

    // bypass
    step(0, 1, 7, 64'd15, 7, 7, 0, 0);
    chk("byp.A", A, 64'd15); chk("byp.B", B, 64'd15);
    step(0, 0, 0, 0, 7, 0, 0, 0);
    chk("byp.hold", A, 64'd15);

    // back-to-back writes, last wins
    step(0, 1, 9, 64'd100, 0, 0, 0, 0);
    step(0, 1, 9, 64'd200, 9, 9, 0, 0);
    chk("b2b.byp", A, 64'd200);
    step(0, 0, 0, 0, 9, 0, 0, 0);
    chk("b2b.A", A, 64'd200);

    // flags
    step(0, 0, 0, 0, 0, 0, 1, 4'b0101);
    chk("flg.set", {60'd0, flags}, 64'h5);
    step(0, 0, 0, 0, 0, 0, 0, 4'b1010);
    chk("flg.hold", {60'd0, flags}, 64'h5);
    step(1, 0, 0, 0, 0, 0, 1, 4'b1010);
    chk("flg.rst", {60'd0, flags}, 64'h0);

    // write-back loop: 1 + 15 -> reg[4]
    step(0, 1, 1, 64'd1, 0, 0, 0, 0);
    step(0, 1, 15, 64'd15, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 15, 0, 0);
    f = A + B;
    step(0, 1, 4, f, 0, 0, 1, 4'b0000);
    step(0, 0, 0, 0, 4, 0, 0, 0);
    chk("loop.A", A, 64'd16); chk("loop.flags", {60'd0, flags}, 64'd0);

    // randomized traffic over a small address window to force collisions
    for (int n = 0; n < 400; n++) begin
      logic [4:0] sa, sb, da;
      sa = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      sb = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      da = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      step($urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1, da,
           {$urandom, $urandom}, sa, sb, $urandom_range(0, 3) == 0, 4'($urandom));
      chk_all("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
